// File: rtl/data_sram_if.sv
// data_sram_if: SRAM-like data-memory handshake between the CPU pipeline and its data memory.
interface data_sram_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   modport master (output req, wr, size, addr, wstrb, wdata, input addr_ok, data_ok, rdata);
   modport slave  (input req, wr, size, addr, wstrb, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-memory responder with in-order, fixed-latency data_ok responses.
// Define SRAM_RESP_RAND_STALL_EN to add LFSR-driven random accept and response stalls.
module data_sram_responder #(
   parameter int ADDR_WIDTH   = 12,
   parameter int RESP_LATENCY = 2,
   parameter int OUTSTANDING  = 2
) (
   input logic        clk,
   input logic        reset,
   data_sram_if.slave data_sram
);
   localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
   localparam int CW = RESP_LATENCY > 1 ? $clog2(RESP_LATENCY) : 1;
   localparam int NW = $clog2(OUTSTANDING + 1);
   // Stored value already accounts for the decrement of the accept cycle itself
   localparam logic [CW-1:0] CNT_INIT = CW'(RESP_LATENCY > 1 ? RESP_LATENCY - 2 : 0);
   logic [31:0]           mem [2**ADDR_WIDTH];
   logic [31:0]           fifo_data [OUTSTANDING];
   logic [CW-1:0]         fifo_cnt  [OUTSTANDING];
   logic [PW-1:0]         head, tail;
   logic [NW-1:0]         count;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           rd_word, head_data;
   logic                  stall_acc, stall_pop, push, pop, head_due;
   logic                  unused_bits;
   assign idx         = data_sram.addr[ADDR_WIDTH+1:2];
   assign rd_word     = mem[idx];
   assign unused_bits = ^{data_sram.size, data_sram.addr[31:ADDR_WIDTH+2], data_sram.addr[1:0]};
`ifdef SRAM_RESP_RAND_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge clk)
      lfsr <= reset ? 16'hACE1 : {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign stall_acc = lfsr[0];
   assign stall_pop = lfsr[1];
`else
   assign stall_acc = 1'b0;
   assign stall_pop = 1'b0;
`endif
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
   endfunction
   always_comb begin
      data_sram.addr_ok = data_sram.req && count < NW'(OUTSTANDING) && !stall_acc;
      push      = data_sram.addr_ok;
      // An empty FIFO with single-cycle latency lets the entry being pushed pop at once
      head_due  = count != '0 ? fifo_cnt[head] == '0 : push && RESP_LATENCY == 1;
      head_data = count != '0 ? fifo_data[head] : (data_sram.wr ? '0 : rd_word);
      pop       = head_due && !stall_pop;
   end
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (push && data_sram.wr && data_sram.wstrb[i] && !reset)
            mem[idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
   always_ff @(posedge clk) begin
      for (int i = 0; i < OUTSTANDING; i++)
         if (fifo_cnt[i] != '0) fifo_cnt[i] <= fifo_cnt[i] - 1'b1;
      if (push) begin
         fifo_cnt[tail]  <= CNT_INIT;
         fifo_data[tail] <= data_sram.wr ? '0 : rd_word;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         data_sram.data_ok <= 1'b0;
         data_sram.rdata   <= '0;
      end else begin
         if (push) tail <= nxt(tail);
         if (pop) head <= nxt(head);
         count             <= count + NW'(push) - NW'(pop);
         data_sram.data_ok <= pop;
         data_sram.rdata   <= pop ? head_data : '0;
      end
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: random and directed traffic against a queue-based response model.
module tb_data_sram_responder;
   localparam int AW = 12;
   localparam int L  = 2;
   localparam int O  = 2;
   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   resp_t       exp_q[$];
   logic [31:0] resp_log[$];
   logic [31:0] ref_mem [2**AW];
   logic [8:0]  t4_ok  = 9'b000010011;
   logic [8:0]  t4_dok = 9'b100110000;
   logic [31:0] d;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   data_sram_if bus();
   data_sram_if bus4();
   data_sram_responder #(.ADDR_WIDTH(AW), .RESP_LATENCY(L), .OUTSTANDING(O)) dut (
      .clk(clk), .reset(reset), .data_sram(bus.slave));
   data_sram_responder #(.ADDR_WIDTH(AW), .RESP_LATENCY(4), .OUTSTANDING(2)) dut4 (
      .clk(clk), .reset(reset), .data_sram(bus4.slave));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
      end
   endtask
   // Reference model: each accepted request owes one response, due L cycles after acceptance
   always @(negedge clk) begin : cmp
      logic hit, acc, want_ok;
      logic [AW-1:0] idx;
      if (reset) exp_q.delete();
      else begin
`ifdef SRAM_RESP_RAND_STALL_EN
         hit = bus.data_ok;
         if (hit && exp_q.size() == 0) check("unexpected data_ok", bus.data_ok, 1'b0);
`else
         hit = exp_q.size() != 0 && exp_q[0].due == cyc;
         check("data_ok", bus.data_ok, hit);
`endif
         if (hit && exp_q.size() != 0) begin
            check("rdata", bus.rdata, exp_q[0].data);
            void'(exp_q.pop_front());
         end
         want_ok = bus.req && exp_q.size() < O;
`ifdef SRAM_RESP_RAND_STALL_EN
         if (bus.addr_ok) check("addr_ok beyond capacity", want_ok, 1'b1);
         acc = bus.req && bus.addr_ok;
`else
         check("addr_ok", bus.addr_ok, want_ok);
         acc = want_ok;
`endif
         if (acc) begin
            idx = bus.addr[AW+1:2];
            exp_q.push_back('{cyc + L, bus.wr ? 32'h0 : ref_mem[idx]});
            if (bus.wr)
               for (int i = 0; i < 4; i++)
                  if (bus.wstrb[i]) ref_mem[idx][8*i +: 8] = bus.wdata[8*i +: 8];
         end
      end
   end
   always @(negedge clk) if (!reset && bus.data_ok) resp_log.push_back(bus.rdata);
   task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
      int n = 0;
      logic ok;
      bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wstrb = s; bus.wdata = wd; bus.size = 2'd2;
      do begin
         @(negedge clk);
         ok = bus.addr_ok;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) check("accept timeout", {31'b0, ok}, 1);
      bus.req = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         bus.req = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask
   task automatic get_resp(output logic [31:0] r);
      int n = 0;
      while (resp_log.size() == 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (resp_log.size() == 0) begin
         check("response timeout", resp_log.size(), 1);
         r = '0;
      end else r = resp_log.pop_front();
   endtask
   task automatic random_phase();
      int w;
      logic [31:0] a;
      for (int k = 0; k < 16; k++) issue(1'b1, 32'((k + 'h40) << 2), 4'hF, $urandom);
      for (int k = 0; k < 200; k++) begin
         w = 'h40 + $urandom_range(0, 15);
         a = ($urandom & 32'hFFFF_C003) | 32'(w << 2);
         issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(posedge clk);
         w++;
      end
      #1;
      check("drain outstanding", exp_q.size(), 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bus.req = 0; bus.wr = 0; bus.size = 0; bus.addr = 0; bus.wstrb = 0; bus.wdata = 0;
      bus4.req = 0; bus4.wr = 0; bus4.size = 0; bus4.addr = 0; bus4.wstrb = 0; bus4.wdata = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle addr_ok", bus.addr_ok, 0);
         check("idle data_ok", bus.data_ok, 0);
         check("idle rdata", bus.rdata, 0);
      end
      @(posedge clk);
      #1;
      resp_log.delete();
      issue(1'b1, 32'h10, 4'hF, 32'h12345678);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      get_resp(d);
      check("write response rdata", d, 32'h0);
      get_resp(d);
      check("read after write", d, 32'h12345678);
      issue(1'b1, 32'h10, 4'b0010, 32'h0000AB00);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      get_resp(d);
      check("partial write response", d, 32'h0);
      get_resp(d);
      check("read after byte write", d, 32'h1234AB78);
`ifndef SRAM_RESP_RAND_STALL_EN
      bus4.req = 1'b1; bus4.wr = 1'b0; bus4.addr = 32'h20; bus4.size = 2'd2;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check("lat4 addr_ok", bus4.addr_ok, t4_ok[k]);
         check("lat4 data_ok", bus4.data_ok, t4_dok[k]);
         @(posedge clk);
         #1;
         if (k == 4) bus4.req = 1'b0;
      end
`endif
      idle(3);
      resp_log.delete();
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(6);
      check("dropped after reset", resp_log.size(), 0);
      issue(1'b0, 32'hFFFF_C010, 4'h0, 32'h0);
      get_resp(d);
      check("persist across reset", d, 32'h1234AB78);
      random_phase();
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
